clk_freq_scan_ctrl: RTL

Scheduler that shares one external clock-frequency counter core among the board's differential clock inputs (200 MHz reference, LF/RT x12/x4 refclks, TCDS40, LHC). It drives the core's input mux select, clear and gate window, and collects each result into a per-channel register file. It sits in the top level between the IBUFDS clock outputs and the slow-control register map. It runs a continuous round-robin scan over enabled channels and accepts on-demand single-channel requests from software.

---
 rtl/clk_freq_scan_pkg.sv | 32 +++
 rtl/rr_next_ch.sv | 32 +++
 rtl/clk_freq_scan_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/clk_freq_scan_pkg.sv
// Shared state encoding, board channel map and status record for the
// clock-frequency scan controller.
package clk_freq_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_CLEAR     = 3'd2,
        ST_GATE      = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_STORE     = 3'd5
    } state_e;

    localparam int unsigned CH_CLK200 = 0;
    localparam int unsigned CH_LF_X12 = 1;
    localparam int unsigned CH_LF_X4  = 2;
    localparam int unsigned CH_RT_X12 = 3;
    localparam int unsigned CH_RT_X4  = 4;
    localparam int unsigned CH_TCDS40 = 5;
    localparam int unsigned CH_LHC    = 6;

    typedef struct packed {
        logic valid;
        logic timeout;
    } ch_status_t;

    // Down-counter load value for a state lasting `cycles` cycles; 0 behaves as 1.
    function automatic logic [31:0] cycles_to_load(input int unsigned cycles);
        return (cycles == 0) ? 32'd0 : 32'(cycles - 1);
    endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin search: first set mask bit strictly after ptr, wrapping to the
// lowest index; found is low when the mask is empty.
module rr_next_ch
    import clk_freq_scan_pkg::*;
#(
    parameter int unsigned N_CH = 7,
    parameter int unsigned CH_W = 3
) (
    input  logic [N_CH-1:0] mask,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] next_ch,
    output logic            found
);

    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && mask[i] && (i > 32'(ptr))) begin
                found   = 1'b1;
                next_ch = CH_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && mask[i] && (i <= 32'(ptr))) begin
                found   = 1'b1;
                next_ch = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/clk_freq_scan_ctrl.sv
// Time-shares one external frequency counter core across the board clock
// inputs: round-robin scan plus prioritised software requests.
module clk_freq_scan_ctrl
    import clk_freq_scan_pkg::*;
#(
    parameter int unsigned N_CH           = 7,
    parameter int unsigned CH_W           = 3,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned GATE_CYCLES    = 200_000_000,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic             req_valid,
    input  logic [CH_W-1:0]  req_ch,
    output logic             req_ready,
    output logic [CH_W-1:0]  meas_sel,
    output logic             meas_clr,
    output logic             meas_gate,
    input  logic             meas_done,
    input  logic [CNT_W-1:0] meas_count,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [CNT_W-1:0] rd_count,
    output logic             rd_valid,
    output logic             rd_timeout,
    output logic             busy,
    output logic             scan_done
);

    localparam logic [31:0] SETTLE_LD  = cycles_to_load(SETTLE_CYCLES);
    localparam logic [31:0] GATE_LD    = cycles_to_load(GATE_CYCLES);
    localparam logic [31:0] TIMEOUT_LD = cycles_to_load(TIMEOUT_CYCLES);

    state_e           state;
    logic [31:0]      timer;
    logic [CH_W-1:0]  ch;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  next_ch;
    logic [CH_W-1:0]  top_ch;
    logic             next_found;
    logic             is_req;
    logic             to_flag;
    logic             req_ok;
    logic [CNT_W-1:0] result;
    logic [CNT_W-1:0] count_rf  [N_CH];
    ch_status_t       status_rf [N_CH];

    rr_next_ch #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_next_ch (
        .mask    (ch_mask),
        .ptr     (rr_ptr),
        .next_ch (next_ch),
        .found   (next_found)
    );

    always_comb begin
        top_ch = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch_mask[i]) top_ch = CH_W'(i);
        end
    end

    assign req_ok    = (32'(req_ch) < N_CH);
    assign req_ready = (state == ST_IDLE) && req_valid;
    assign meas_sel  = ch;
    assign meas_clr  = (state == ST_CLEAR);
    assign meas_gate = (state == ST_GATE);
    assign busy      = (state != ST_IDLE);
    assign scan_done = (state == ST_STORE) && !is_req && (|ch_mask) && (ch == top_ch);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            timer   <= '0;
            ch      <= '0;
            rr_ptr  <= CH_W'(N_CH - 1);
            is_req  <= 1'b0;
            to_flag <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // An out-of-range request is acknowledged but never measured.
                    if (req_valid) begin
                        if (req_ok) begin
                            ch     <= req_ch;
                            is_req <= 1'b1;
                            timer  <= SETTLE_LD;
                            state  <= ST_SELECT;
                        end
                    end else if (enable && next_found) begin
                        ch     <= next_ch;
                        is_req <= 1'b0;
                        timer  <= SETTLE_LD;
                        state  <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (timer == '0) state <= ST_CLEAR;
                    else             timer <= timer - 1'b1;
                end
                ST_CLEAR: begin
                    timer <= GATE_LD;
                    state <= ST_GATE;
                end
                ST_GATE: begin
                    if (timer == '0) begin
                        timer <= TIMEOUT_LD;
                        state <= ST_WAIT_DONE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (meas_done) begin
                        result  <= meas_count;
                        to_flag <= 1'b0;
                        state   <= ST_STORE;
                    end else if (timer == '0) begin
                        result  <= '0;
                        to_flag <= 1'b1;
                        state   <= ST_STORE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_STORE: begin
                    if (!is_req) rr_ptr <= ch;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Readback samples the file before this cycle's STORE write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                count_rf[i]  <= '0;
                status_rf[i] <= '0;
            end
            rd_count   <= '0;
            rd_valid   <= 1'b0;
            rd_timeout <= 1'b0;
        end else begin
            if (32'(rd_ch) < N_CH) begin
                rd_count   <= count_rf[rd_ch];
                rd_valid   <= status_rf[rd_ch].valid;
                rd_timeout <= status_rf[rd_ch].timeout;
            end else begin
                rd_count   <= '0;
                rd_valid   <= 1'b0;
                rd_timeout <= 1'b0;
            end
            if ((state == ST_STORE) && (32'(ch) < N_CH)) begin
                count_rf[ch]  <= result;
                status_rf[ch] <= '{valid: 1'b1, timeout: to_flag};
            end
        end
    end

endmodule
